// File: rtl/csm_dual_port_responder_if.sv
// One CSM processor-bus port: multiplexed address/data command side plus ack/err/read-data response.
// The master drives commands; the responder (slave) returns status and read data.
interface csm_dual_port_responder_if #(
    parameter int DATABITS = 8,
    parameter int ERRBITS  = 2
);
    logic [DATABITS-1:0] in_ad;
    logic                rw;
    logic                enable;
    logic                hold;
    logic                release_req;
    logic                ack;
    logic [ERRBITS-1:0]  err;
    logic [DATABITS-1:0] out_data;

    modport master (
        output in_ad, rw, enable, hold, release_req,
        input  ack, err, out_data
    );

    modport slave (
        input  in_ad, rw, enable, hold, release_req,
        output ack, err, out_data
    );
endinterface

// File: rtl/csm_dual_port_responder.sv
// Shared-memory responder for two CSM bus ports with hold/release exclusive ownership.
// state  | meaning
// IDLE   | ack=1, waiting for enable
// WDATA  | address latched, write data sampled on next edge
// RRESP  | address latched, read data returned on next edge
// CTRL   | hold/release resolved on next edge
module csm_dual_port_responder #(
    parameter int DATABITS = 8,
    parameter int ERRBITS  = 2,
    parameter int DEPTH    = 256
) (
    input logic                     clk,
    input logic                     reset_n,
    csm_dual_port_responder_if.slave a_port,
    csm_dual_port_responder_if.slave b_port
);
    // DEPTH is expected to be a power of two so address truncation gives the modulo wrap.
    localparam int ADDRBITS = $clog2(DEPTH);

    localparam logic [ERRBITS-1:0] ERR_OK   = ERRBITS'(0);
    localparam logic [ERRBITS-1:0] ERR_DENY = ERRBITS'(1);
    localparam logic [ERRBITS-1:0] ERR_REL  = ERRBITS'(2);
    localparam logic [ERRBITS-1:0] ERR_CONF = ERRBITS'(3);

    typedef enum logic [1:0] {S_IDLE, S_WDATA, S_RRESP, S_CTRL} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} owner_t;

    function automatic owner_t own_of(input int p);
        return (p == 0) ? OWN_A : OWN_B;
    endfunction

    logic [DATABITS-1:0] in_ad    [2];
    logic                rw       [2];
    logic                enable   [2];
    logic                hold     [2];
    logic                rel      [2];

    state_t              state    [2];
    logic [ADDRBITS-1:0] addr_q   [2];
    logic                denied_q [2];
    logic                hold_q   [2];
    logic                rel_q    [2];
    logic                ack_q    [2];
    logic [ERRBITS-1:0]  err_q    [2];
    logic [DATABITS-1:0] out_q    [2];
    owner_t              owner;

    logic [DATABITS-1:0] mem [DEPTH];

    owner_t              own_nxt;
    logic [ERRBITS-1:0]  ctrl_err [2];
    logic                wr_ok    [2];
    logic                collide;

    assign in_ad[0]  = a_port.in_ad;
    assign in_ad[1]  = b_port.in_ad;
    assign rw[0]     = a_port.rw;
    assign rw[1]     = b_port.rw;
    assign enable[0] = a_port.enable;
    assign enable[1] = b_port.enable;
    assign hold[0]   = a_port.hold;
    assign hold[1]   = b_port.hold;
    assign rel[0]    = a_port.release_req;
    assign rel[1]    = b_port.release_req;

    assign a_port.ack      = ack_q[0];
    assign b_port.ack      = ack_q[1];
    assign a_port.err      = err_q[0];
    assign b_port.err      = err_q[1];
    assign a_port.out_data = out_q[0];
    assign b_port.out_data = out_q[1];

    // Port A's control op is resolved before port B's, so A wins a simultaneous hold.
    always_comb begin
        own_nxt     = owner;
        ctrl_err[0] = ERR_OK;
        ctrl_err[1] = ERR_OK;
        for (int p = 0; p < 2; p++) begin
            if (state[p] == S_CTRL) begin
                if (hold_q[p] && rel_q[p]) begin
                    ctrl_err[p] = ERR_CONF;
                end else if (hold_q[p]) begin
                    if (own_nxt == OWN_NONE) begin
                        own_nxt = own_of(p);
                    end else if (own_nxt != own_of(p)) begin
                        ctrl_err[p] = ERR_DENY;
                    end
                end else if (own_nxt == own_of(p)) begin
                    own_nxt = OWN_NONE;
                end else begin
                    ctrl_err[p] = ERR_REL;
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            wr_ok[p] = (state[p] == S_WDATA) && !denied_q[p];
        end
        collide = wr_ok[0] && wr_ok[1] && (addr_q[0] == addr_q[1]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner <= OWN_NONE;
            for (int p = 0; p < 2; p++) begin
                state[p]    <= S_IDLE;
                addr_q[p]   <= '0;
                denied_q[p] <= 1'b0;
                hold_q[p]   <= 1'b0;
                rel_q[p]    <= 1'b0;
                ack_q[p]    <= 1'b1;
                err_q[p]    <= ERR_OK;
                out_q[p]    <= '0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            owner <= own_nxt;
            for (int p = 0; p < 2; p++) begin
                case (state[p])
                    S_IDLE: begin
                        if (enable[p]) begin
                            ack_q[p]    <= 1'b0;
                            addr_q[p]   <= in_ad[p][ADDRBITS-1:0];
                            denied_q[p] <= (owner != OWN_NONE) && (owner != own_of(p));
                            hold_q[p]   <= hold[p];
                            rel_q[p]    <= rel[p];
                            if (hold[p] || rel[p]) begin
                                state[p] <= S_CTRL;
                            end else if (rw[p]) begin
                                state[p] <= S_WDATA;
                            end else begin
                                state[p] <= S_RRESP;
                            end
                        end
                    end
                    S_WDATA: begin
                        state[p] <= S_IDLE;
                        ack_q[p] <= 1'b1;
                        if (denied_q[p]) begin
                            err_q[p] <= ERR_DENY;
                        end else if (p == 1 && collide) begin
                            err_q[p] <= ERR_CONF;
                        end else begin
                            mem[addr_q[p]] <= in_ad[p];
                            err_q[p]       <= ERR_OK;
                        end
                    end
                    S_RRESP: begin
                        state[p] <= S_IDLE;
                        ack_q[p] <= 1'b1;
                        if (denied_q[p]) begin
                            err_q[p] <= ERR_DENY;
                        end else begin
                            out_q[p] <= mem[addr_q[p]];
                            err_q[p] <= ERR_OK;
                        end
                    end
                    default: begin
                        state[p] <= S_IDLE;
                        ack_q[p] <= 1'b1;
                        err_q[p] <= ctrl_err[p];
                    end
                endcase
            end
        end
    end
endmodule

// File: doc/csm_dual_port_responder.md
Name: csm_dual_port_responder

Overview:
- Responder end of the CSM processor bus: the shared-memory controller that processor A and processor B command.
- Accepts multiplexed address/data read, write, hold and release transactions on two identical ports.
- Serves reads and writes from one shared DEPTH x DATABITS memory.
- Arbitrates exclusive ownership (hold/release) and reports status on per-port ack/err.

Parameters:
DATABITS, 8, data and address width; memory address = in_AD[ADDRBITS-1:0]
ERRBITS, 2, error/status code width
DEPTH, 256, memory words; ADDRBITS = $clog2(DEPTH) <= DATABITS

Ports:
clk  input  1  system clock, all state on posedge
reset_n  input  1  asynchronous active-low reset
A_in_AD  input  DATABITS  port A address (command cycle) / write data (data cycle)
A_rw  input  1  1 = write, 0 = read
A_enable  input  1  port A command strobe
A_hold  input  1  request exclusive ownership
A_release  input  1  give up exclusive ownership
A_ack  output  1  1 = port A idle and ready; 0 = command in progress
A_err  output  ERRBITS  status of last completed port A command
A_out_data  output  DATABITS  port A read data
B_in_AD, B_rw, B_enable, B_hold, B_release, B_ack, B_err, B_out_data: identical set for port B

Behaviour:
- Reset (async, reset_n=0):
  - ack=1 on both ports; err=0; out_data=0.
  - Lock owner = NONE; all memory words = 0.
  - Both FSMs return to IDLE. Any in-flight write is discarded; no partial write.
- Per-port FSM states: IDLE (ack=1), WDATA (ack=0), RRESP (ack=0), CTRL (ack=0).
- Command acceptance: at a posedge where the port is in IDLE and enable=1. Decode priority: hold/release > rw.
  - hold=1 or release=1 -> CTRL.
  - rw=1 -> WDATA; address latched from in_AD.
  - rw=0 -> RRESP; address latched from in_AD.
- Permission check at acceptance: read/write is denied if the lock owner is the other port.
  - Denied ops still walk the same FSM path, so timing is unchanged.
  - A denied write does not modify memory.
  - A denied read leaves out_data unchanged.
  - Completion err = 01.
- Write: address at posedge k; in_AD sampled as data at posedge k+1; memory written at k+1. The port returns to IDLE with ack=1 after k+1.
- Read: address at posedge k; out_data <= mem[addr] at posedge k+1; ack=1 after k+1. out_data holds until the next successful read.
- CTRL completes at posedge k+1; ack=1 after k+1.
  - hold, owner NONE -> owner = this port, err 00.
  - hold, owner = self -> no change, err 00.
  - hold, owner = other -> err 01.
  - release, owner = self -> owner NONE, err 00.
  - release, owner != self -> err 10.
  - hold and release both 1 -> no change, err 11.
- err update: err is updated at completion (the edge on which ack returns to 1) and held until the next completion.
- Simultaneous events:
  - Both ports hold in the same cycle with owner NONE: A wins (err 00); B gets err 01.
  - Both ports complete writes to the same address on the same posedge: A's data is stored; B's write is dropped with err 11.
  - Cross-port read and write to the same address on the same posedge: the read returns the old data (read-before-write).
- enable high while ack=0 is ignored. A new command may be accepted on the first posedge after ack returns to 1, giving a throughput of one command per 2 cycles per port.
- Addresses wrap modulo DEPTH (upper in_AD bits are ignored).

Test Plan:
- Reset then A writes 0x3C to addr 0x10, A reads 0x10 -> A_out_data=0x3C, A_err=00, A_ack low for exactly 1 cycle per command phase.
- A hold, then B writes 0x55 to 0x10 -> B_err=01 and mem[0x10] stays 0x3C. A release, then B repeats the write -> B_err=00 and A reads 0x55.
- B release with no lock -> B_err=10. A hold+release asserted together -> A_err=11 and owner unchanged.
- A and B hold on the same posedge -> A_err=00, B_err=01. Then B read denied -> B_out_data unchanged, B_err=01.
- A writes 0xAA and B writes 0xBB to addr 0x20, both completing on the same edge -> mem[0x20]=0xAA, B_err=11. A write 0x11 to 0x30 racing a B read of 0x30 -> B gets the old value 0x00.
- reset_n pulsed low during A's WDATA cycle for 0x40 -> A_ack=1, err=0, owner NONE, subsequent read of 0x40 returns 0x00.
